dec_rr_arbiter: RTL and testbench
=================================

# dec_rr_arbiter

Round-robin arbiter that shares the 3-to-8 decoder between eight requesters. It drives the decoder's 3-bit select `x` and enable `en` from registered state, and exposes the resulting one-hot grant vector. It sits between requesting blocks and the decoder-driven resource, and sequences ownership so that exactly one requester is selected at a time.

## Interface
- `HOLD_MAX`, default 15: maximum consecutive GRANT cycles for one owner while another requester waits. Used only when `ARB_TIMEOUT_EN` is defined. Legal range 2..255.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  8  request lines; `req[i]` is held high until requester i is done.
- `x`  out  3  select for the decoder: index of the current or last owner (registered).
- `en`  out  1  grant valid and decoder enable (registered).
- `gnt`  out  8  one-hot grant, `en ? (8'b1 << x) : 8'b0`; decoded combinationally from the registered `x` and `en`.
- `busy`  out  1  equals `en`; kept for requester-side handshake.

## Operation
- State machine has two states:
  - IDLE: `en`=0.
  - GRANT: `en`=1, owner = `x`.
- Internal pointer `ptr[2:0]` holds the last granted index. The search order is `ptr+1, ptr+2, …` modulo 8, so 7 wraps to 0.
- **IDLE**
  - If `req` != 0: go to GRANT. `x` = first set bit in search order, `ptr` = that index.
  - Otherwise stay in IDLE; `x` keeps its old value.
- **GRANT, owner releases (`req[x]`=0)**
  - If another bit of `req` is set: switch directly to the next requester in search order from `x+1`. There is no idle bubble and `en` stays 1.
  - Otherwise go to IDLE with `en`=0. `x` and `ptr` keep the last owner.
- **GRANT, `req[x]`=1:** hold the grant. The only exception is a timeout (see Configuration).
- **Requests during GRANT:** a request that rises and falls while another requester owns the grant is lost. Requesters must hold `req` until they see `gnt`.
- **Priority:** the owner never gets back-to-back priority. After a release, the search starts at `x+1`, so the same index wins again only if it is the sole requester.
- **Output invariant:** `gnt` is always zero or one-hot, and never changes except on a clock edge or on reset.

## Timing
- **Reset values** (applied on `rst_n`=0, immediately and asynchronously):
  - state IDLE
  - `ptr`=3'd7, so the first search starts at index 0
  - `x`=3'd0
  - `en`=0, `gnt`=8'h00, `busy`=0
  - hold counter = 0
- **Latency:**
  - `req` sampled at edge k gives `en`/`gnt` valid after edge k, i.e. one cycle from the request.
  - A release sampled at edge k changes the grant after edge k.
- **Owner switch:** a handover between requesters is a single edge; `gnt` moves from one one-hot value to the next with no zero cycle.
- **Reset during GRANT:** outputs clear at once and the pointer returns to 7. After reset, arbitration restarts from index 0.
- **Simultaneous release and new request** on the same edge: the new request is included in that edge's search.

## Configuration
- **Macro `ARB_TIMEOUT_EN` defined:**
  - An 8-bit hold counter clears on every grant change and increments on each GRANT cycle.
  - When the counter reaches `HOLD_MAX-1`, `req[x]`=1, and at least one other `req` bit is set, the next edge forces a switch to the next requester in search order. The counter then clears.
  - If no other requester is waiting, the grant is kept and the counter saturates at `HOLD_MAX-1`.
- **Macro `ARB_TIMEOUT_EN` not defined:**
  - No counter is built and `HOLD_MAX` is ignored.
  - The owner keeps the grant for as long as `req[x]` stays high.

## Test plan
- **Reset and first grant.** Hold `rst_n`=0 for 100 ns, then raise it with `req`=8'h00 → `en`=0 and `gnt`=8'h00. Set `req`=8'h81 → after one edge, `x`=0 and `gnt`=8'h01.
- **Rotation.** Hold `req`=8'hFF and have each owner drop its bit for one cycle after owning the grant → the grant order is 0,1,2,…,7,0, with no cycle where `gnt`=0.
- **Wrap-around search.** From owner `x`=6, set `req`=8'h05 and drop bit 6 → next `gnt`=8'h01 (index 0), then 8'h04 after bit 0 releases.
- **Idle return.** With owner 3 and `req`=8'h08, drop `req` to 8'h00 → `en`=0, `gnt`=8'h00, `x` stays 3. Then set `req`=8'h08 → owner 3 again, since it is the sole requester.
- **Asynchronous reset mid-grant.** With owner 5, pulse `rst_n` low between clock edges → `gnt`=8'h00 immediately. After release with `req`=8'h30, the first grant goes to index 4.
- **Timeout (`ARB_TIMEOUT_EN`, `HOLD_MAX`=4).** Hold `req`=8'h03 with neither requester releasing → the owner alternates 0,1,0 every 4 cycles. With `req`=8'h01 only, the grant stays on 0 indefinitely.

Source files
------------

// File: rtl/dec_rr_arbiter.sv
// rtl/dec_rr_arbiter.sv - round-robin arbiter driving a shared 3-to-8 decoder select/enable
// Optional owner timeout enabled by defining ARB_TIMEOUT_EN.
module dec_rr_arbiter #(
  parameter int HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [2:0] x,
  output logic       en,
  output logic [7:0] gnt,
  output logic       busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state, state_nxt;
  logic [2:0] ptr, ptr_nxt, x_nxt;
  logic [3:0] pick_idle, pick_next;
  logic       new_grant;
  logic       timeout_hit;

  // First set bit of r scanning base, base+1, ... modulo 8; bit 3 flags a hit.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] base);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0;
    for (int i = 7; i >= 0; i--) begin
      idx = base + 3'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign pick_idle = rr_pick(req, ptr + 3'd1);
  assign pick_next = rr_pick(req & ~(8'b1 << x), x + 3'd1);

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  logic [7:0] hold_cnt, hold_nxt;

  assign timeout_hit = (hold_cnt == HOLD_LAST);

  always_comb begin
    hold_nxt = 8'd0;
    if (state_nxt == GRANT && !new_grant)
      hold_nxt = (hold_cnt == HOLD_LAST) ? hold_cnt : hold_cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_cnt <= 8'd0;
    else        hold_cnt <= hold_nxt;
  end
`else
  logic [7:0] hold_max_unused;
  assign hold_max_unused = 8'(HOLD_MAX);
  assign timeout_hit     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 3'd7;
      x     <= 3'd0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      x     <= x_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    ptr_nxt   = ptr;
    new_grant = 1'b0;
    case (state)
      IDLE: begin
        if (pick_idle[3]) begin
          state_nxt = GRANT;
          x_nxt     = pick_idle[2:0];
          ptr_nxt   = pick_idle[2:0];
          new_grant = 1'b1;
        end
      end
      GRANT: begin
        // A release and a forced timeout hand over identically, with no idle bubble.
        if ((!req[x] || timeout_hit) && pick_next[3]) begin
          x_nxt     = pick_next[2:0];
          ptr_nxt   = pick_next[2:0];
          new_grant = 1'b1;
        end else if (!req[x]) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    en   = (state == GRANT);
    busy = en;
    gnt  = en ? (8'b1 << x) : 8'b0;
  end

endmodule

// File: tb/tb_dec_rr_arbiter.sv
// tb/tb_dec_rr_arbiter.sv - directed self-checking bench for dec_rr_arbiter
module tb_dec_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [2:0] x;
  logic       en;
  logic [7:0] gnt;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  dec_rr_arbiter #(.HOLD_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .x     (x),
    .en    (en),
    .gnt   (gnt),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_g;
    rst_n = 1'b0;
    req   = 8'h00;
    #100;
    check("rst_en", en, 0);
    check("rst_gnt", gnt, 8'h00);
    check("rst_x", x, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();
    check("idle_en", en, 0);
    check("idle_gnt", gnt, 8'h00);

    req = 8'h81;
    tick();
    check("first_x", x, 0);
    check("first_gnt", gnt, 8'h01);
    check("first_busy", busy, 1);

    // Rotation: current owner drops its bit, everyone else keeps requesting.
    for (int k = 1; k <= 8; k++) begin
      req = 8'hFF & ~(8'b1 << ((k - 1) % 8));
      tick();
      exp_g = 8'b1 << (k % 8);
      check("rot_gnt", gnt, exp_g);
      check("rot_en", en, 1);
    end

    req = 8'h40;
    tick();
    check("wrap_own6", gnt, 8'h40);
    req = 8'h05;
    tick();
    check("wrap_to0", gnt, 8'h01);
    check("wrap_x0", x, 0);
    req = 8'h04;
    tick();
    check("wrap_to2", gnt, 8'h04);

    req = 8'h08;
    tick();
    check("idle_own3", gnt, 8'h08);
    req = 8'h00;
    tick();
    check("ret_en", en, 0);
    check("ret_gnt", gnt, 8'h00);
    check("ret_x", x, 3);
    req = 8'h08;
    tick();
    check("sole_gnt", gnt, 8'h08);
    check("sole_x", x, 3);

    req = 8'h20;
    tick();
    check("own5", gnt, 8'h20);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_gnt", gnt, 8'h00);
    check("arst_en", en, 0);
    check("arst_x", x, 0);
    req = 8'h30;
    #1;
    rst_n = 1'b1;
    tick();
    check("post_rst_gnt", gnt, 8'h10);
    check("post_rst_x", x, 4);

    // Release of owner 4 with a fresh request on bit 1 in the same edge.
    req = 8'h02;
    tick();
    check("simul_gnt", gnt, 8'h02);

`ifdef ARB_TIMEOUT_EN
    req = 8'h03;
    for (int t = 1; t <= 12; t++) begin
      tick();
      exp_g = (((t / 4) % 2) != 0) ? 8'h01 : 8'h02;
      check("tmo_alt", gnt, exp_g);
    end
    req = 8'h01;
    for (int t = 0; t < 10; t++) begin
      tick();
      check("tmo_sole", gnt, 8'h01);
    end
`else
    req = 8'h03;
    for (int t = 0; t < 20; t++) begin
      tick();
      check("hold_gnt", gnt, 8'h02);
    end
`endif

    req = 8'h00;
    tick();
    check("final_idle", en, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
